// File: rtl/fma16_pkg.sv
// fma16_pkg: shared constants, rounding-mode encoding and flag positions for the fma16 datapath.
package fma16_pkg;

  localparam int VEC_SIZE  = 88;
  localparam int END_BITS  = 22;
  localparam int ONE_POS   = END_BITS + 20;
  localparam int FRAC_LSB  = END_BITS + 10;
  localparam int GUARD_POS = END_BITS + 9;
  localparam int SUB_SAT   = 24;

  localparam int BIAS = 15;
  localparam int EMAX = 31;
  localparam logic [14:0] MAXNORM = 15'h7BFF;
  localparam logic [14:0] INF     = 15'h7C00;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef enum logic [1:0] {
    RZ  = 2'b00,
    RNE = 2'b01,
    RDN = 2'b10,
    RUP = 2'b11
  } round_mode_e;

  // Overflow goes to infinity when rounding toward it, otherwise clamps to the largest finite value.
  function automatic logic overflow_to_inf(round_mode_e rm, logic sign);
    return (rm == RNE) || (rm == RUP && !sign) || (rm == RDN && sign);
  endfunction

endpackage

// File: rtl/fma16_norm_round_if.sv
// fma16_norm_round_if: input beat and result handshake bundle of the normalize/round back end.
interface fma16_norm_round_if;
  import fma16_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [VEC_SIZE:0]   sm;
  logic signed [7:0]   m_shift;
  logic signed [7:0]   pe;
  logic                sign;
  logic                zero_in;
  logic [1:0]          roundmode;
  logic                out_valid;
  logic                out_ready;
  logic [15:0]         result;
  logic [3:0]          flags;

  modport master (
    output in_valid, sm, m_shift, pe, sign, zero_in, roundmode, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, sm, m_shift, pe, sign, zero_in, roundmode, out_ready,
    output in_ready, out_valid, result, flags
  );

endinterface

// File: rtl/fma16_round_inc.sv
// fma16_round_inc: decides whether the truncated fraction is bumped by one ulp.
module fma16_round_inc
  import fma16_pkg::*;
(
  input  round_mode_e rm,
  input  logic        sign,
  input  logic        lsb,
  input  logic        g,
  input  logic        st,
  output logic        inc
);

  // Directed modes round only toward their own infinity; RNE breaks ties on the fraction lsb.
  always_comb begin
    inc = 1'b0;
    case (rm)
      RZ:      inc = 1'b0;
      RNE:     inc = g & (st | lsb);
      RDN:     inc = sign & (g | st);
      RUP:     inc = ~sign & (g | st);
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/fma16_norm_round.sv
// fma16_norm_round: three-stage shift / round / pack back end producing the fp16 result and flags.
module fma16_norm_round
  import fma16_pkg::*;
(
  input  logic clk,
  input  logic reset,
  fma16_norm_round_if.slave bus
);

  localparam int NSW  = VEC_SIZE + 1;
  localparam int RPAD = 128;

  logic adv;

  logic [7:0]             rsh_amt;
  logic [NSW+RPAD-1:0]    rsh_ext;
  logic [NSW-1:0]         ns_main;
  logic                   main_sticky;
  logic signed [9:0]      e_raw;
  logic signed [9:0]      sub_amt;
  logic [4:0]             sub_sh;
  logic [NSW+SUB_SAT-1:0] sub_ext;

  logic               s1_valid, s1_sticky, s1_sub, s1_sign, s1_zero;
  logic [ONE_POS-1:0] s1_ns;
  logic signed [9:0]  s1_e;
  round_mode_e        s1_rm;

  logic [9:0]         frac;
  logic               guard, st, inc;
  logic [10:0]        frac_sum;

  logic               s2_valid, s2_inexact, s2_sub, s2_sign, s2_zero;
  logic [9:0]         s2_frac;
  logic signed [9:0]  s2_e;
  round_mode_e        s2_rm;

  logic [15:0]        res_next;
  logic [3:0]         flags_next;
  logic               out_valid_q;
  logic [15:0]        result_q;
  logic [3:0]         flags_q;

  assign adv           = !out_valid_q | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

  // Normalizing shift plus the extra denormalizing shift when the exponent falls to zero or below.
  always_comb begin
    rsh_amt     = ~bus.m_shift + 8'd1;
    rsh_ext     = '0;
    ns_main     = '0;
    main_sticky = 1'b0;
    if (!bus.m_shift[7]) begin
      ns_main = bus.sm << bus.m_shift[6:0];
    end else begin
      rsh_ext     = {bus.sm, {RPAD{1'b0}}} >> rsh_amt;
      ns_main     = NSW'(rsh_ext >> RPAD);
      main_sticky = |rsh_ext[RPAD-1:0];
    end
    e_raw   = {{2{bus.pe[7]}}, bus.pe} - {{2{bus.m_shift[7]}}, bus.m_shift};
    sub_amt = 10'sd1 - e_raw;
    sub_sh  = '0;
    if (e_raw <= 10'sd0) begin
      sub_sh = (sub_amt > 10'(SUB_SAT)) ? 5'(SUB_SAT) : sub_amt[4:0];
    end
    sub_ext = {ns_main, {SUB_SAT{1'b0}}} >> sub_sh;
  end

  // Stage 1 register: shifted mantissa below the hidden bit, sticky, exponent and tiny marker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_ns     <= '0;
      s1_sticky <= 1'b0;
      s1_e      <= '0;
      s1_sub    <= 1'b0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_rm     <= RZ;
    end else if (adv) begin
      s1_valid  <= bus.in_valid;
      s1_ns     <= ONE_POS'(sub_ext >> SUB_SAT);
      s1_sticky <= main_sticky | (|sub_ext[SUB_SAT-1:0]);
      s1_e      <= (e_raw <= 10'sd0) ? 10'sd0 : e_raw;
      s1_sub    <= (e_raw <= 10'sd0);
      s1_sign   <= bus.sign;
      s1_zero   <= bus.zero_in;
      s1_rm     <= round_mode_e'(bus.roundmode);
    end
  end

  assign frac     = s1_ns[ONE_POS-1:FRAC_LSB];
  assign guard    = s1_ns[GUARD_POS];
  assign st       = s1_sticky | (|s1_ns[GUARD_POS-1:0]);
  assign frac_sum = {1'b0, frac} + {10'd0, inc};

  fma16_round_inc u_round_inc (
    .rm   (s1_rm),
    .sign (s1_sign),
    .lsb  (frac[0]),
    .g    (guard),
    .st   (st),
    .inc  (inc)
  );

  // Stage 2 register: rounded fraction; a carry out bumps the exponent (subnormal 0 becomes normal 1).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid   <= 1'b0;
      s2_frac    <= '0;
      s2_e       <= '0;
      s2_inexact <= 1'b0;
      s2_sub     <= 1'b0;
      s2_sign    <= 1'b0;
      s2_zero    <= 1'b0;
      s2_rm      <= RZ;
    end else if (adv) begin
      s2_valid   <= s1_valid;
      s2_frac    <= frac_sum[9:0];
      s2_e       <= frac_sum[10] ? s1_e + 10'sd1 : s1_e;
      s2_inexact <= guard | st;
      s2_sub     <= s1_sub;
      s2_sign    <= s1_sign;
      s2_zero    <= s1_zero;
      s2_rm      <= s1_rm;
    end
  end

  // Packing: exact zero, overflow to Inf or MAXNORM by mode, otherwise the normal/subnormal encoding.
  always_comb begin
    res_next   = '0;
    flags_next = '0;
    if (s2_zero) begin
      res_next = {s2_sign, 15'd0};
    end else if (s2_e >= 10'(EMAX)) begin
      res_next = {s2_sign, overflow_to_inf(s2_rm, s2_sign) ? INF : MAXNORM};
      flags_next[FLAG_OVERFLOW] = 1'b1;
      flags_next[FLAG_INEXACT]  = 1'b1;
    end else begin
      res_next = {s2_sign, s2_e[4:0], s2_frac};
      flags_next[FLAG_UNDERFLOW] = s2_sub & s2_inexact;
      flags_next[FLAG_INEXACT]   = s2_inexact;
    end
  end

  // Output register holds the presented result until downstream accepts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        result_q <= res_next;
        flags_q  <= flags_next;
      end
    end
  end

endmodule

// File: tb/tb_fma16_norm_round.sv
// tb_fma16_norm_round: directed and randomized checks of fma16_norm_round against an exact-value rounding model.
module tb_fma16_norm_round;
  import fma16_pkg::*;

  typedef struct {
    logic [VEC_SIZE:0] sm;
    logic signed [7:0] m_shift;
    logic signed [7:0] pe;
    logic              sign;
    logic              zero;
    logic [1:0]        rm;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  int popped = 0;
  bit last_accept;
  beat_t cur_beat;
  logic [19:0] exp_q[$];

  fma16_norm_round_if bus();

  fma16_norm_round dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Value = sm * 2^(pe-15-42); round to fp16 directly from that value, independent of m_shift.
  function automatic logic [19:0] ref_model(beat_t b);
    int p, eb, lsb_pos, n, packed_v;
    logic [319:0] big, tmp, mask;
    logic g, st, inc, tiny, to_inf;
    if (b.zero) return {4'b0000, b.sign, 15'd0};
    p = 0;
    for (int i = 0; i <= VEC_SIZE; i++) if (b.sm[i]) p = i;
    eb = p + int'(b.pe) - 42;
    tiny = (eb <= 0);
    lsb_pos = (tiny ? (33 - int'(b.pe)) : (p - 10)) + 128;
    big = 320'(b.sm) << 128;
    tmp = big >> lsb_pos;
    n = int'(tmp[11:0]);
    g = big[lsb_pos-1];
    mask = (320'd1 << (lsb_pos - 1)) - 320'd1;
    st = |(big & mask);
    case (b.rm)
      2'b00:   inc = 1'b0;
      2'b01:   inc = g && (st || (n % 2 == 1));
      2'b10:   inc = b.sign && (g || st);
      default: inc = !b.sign && (g || st);
    endcase
    n = n + int'(inc);
    packed_v = (tiny ? 0 : (eb - 1) * 1024) + n;
    if (packed_v >= 'h7C00) begin
      to_inf = (b.rm == 2'b01) || (b.rm == 2'b11 && !b.sign) || (b.rm == 2'b10 && b.sign);
      return {4'b0101, b.sign, to_inf ? 15'h7C00 : 15'h7BFF};
    end
    return {2'b00, tiny && (g || st), g || st, b.sign, 15'(packed_v)};
  endfunction

  function automatic beat_t mk(logic [VEC_SIZE:0] sm, int ms, int pe, logic sign, logic [1:0] rm);
    beat_t b;
    b.sm = sm;
    b.m_shift = 8'(ms);
    b.pe = 8'(pe);
    b.sign = sign;
    b.zero = 1'b0;
    b.rm = rm;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    int p, eb;
    p = int'($urandom_range(VEC_SIZE, 0));
    b.sm = '0;
    for (int i = 0; i < p; i++) b.sm[i] = 1'($urandom_range(1, 0));
    b.sm[p] = 1'b1;
    eb = int'($urandom_range(40, 0)) - 8;
    b.pe = 8'(eb - p + 42);
    b.m_shift = 8'(42 - p);
    b.sign = 1'($urandom_range(1, 0));
    b.rm = 2'($urandom_range(3, 0));
    b.zero = ($urandom_range(15, 0) == 0);
    if (b.zero) b.sm = '0;
    return b;
  endfunction

  task automatic check_output(string tag, logic [31:0] observed, logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(beat_t b, logic valid);
    cur_beat = b;
    bus.in_valid = valid;
    bus.sm = b.sm;
    bus.m_shift = b.m_shift;
    bus.pe = b.pe;
    bus.sign = b.sign;
    bus.zero_in = b.zero;
    bus.roundmode = b.rm;
  endtask

  // One clock: record accepted beats in the scoreboard, compare delivered results, advance.
  task automatic tick();
    logic [19:0] expv;
    #1;
    last_accept = bus.in_valid && bus.in_ready;
    if (last_accept) exp_q.push_back(ref_model(cur_beat));
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check_output("spurious_out", 32'(bus.out_valid), 32'd0);
      end else begin
        expv = exp_q.pop_front();
        popped++;
        check_output("stream", {12'd0, bus.flags, bus.result}, {12'd0, expv});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_directed(string tag, beat_t b, logic [15:0] exp_res, logic [3:0] exp_fl);
    int n;
    bus.out_ready = 1'b1;
    apply_stimulus(b, 1'b1);
    tick();
    apply_stimulus(b, 1'b0);
    n = 1;
    while (!bus.out_valid && n < 10) begin
      tick();
      n++;
    end
    check_output({tag, "_lat"}, n, 3);
    check_output({tag, "_res"}, {bus.flags, bus.result}, {exp_fl, exp_res});
    tick();
  endtask

  initial begin
    beat_t bp[5];
    beat_t cur;
    int k;
    logic [VEC_SIZE:0] one42;
    one42 = {{VEC_SIZE{1'b0}}, 1'b1} << 42;

    reset = 1'b0;
    bus.out_ready = 1'b1;
    apply_stimulus(mk('0, 0, 0, 1'b0, 2'b00), 1'b0);
    #12;
    check_output("rst_out_valid", bus.out_valid, 0);
    check_output("rst_result", bus.result, 0);
    check_output("rst_flags", bus.flags, 0);
    check_output("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check_output("post_rst_in_ready", bus.in_ready, 1);

    run_directed("one", mk(one42, 0, 15, 1'b0, 2'b01), 16'h3C00, 4'b0000);
    run_directed("four", mk(one42 << 2, -2, 15, 1'b0, 2'b01), 16'h4400, 4'b0000);
    run_directed("ovf_rne", mk(one42 << 2, -2, 29, 1'b0, 2'b01), 16'h7C00, 4'b0101);
    run_directed("ovf_rz", mk(one42 << 2, -2, 29, 1'b0, 2'b00), 16'h7BFF, 4'b0101);
    run_directed("ovf_rup_neg", mk(one42 << 2, -2, 29, 1'b1, 2'b11), 16'hFBFF, 4'b0101);
    run_directed("ovf_rdn_neg", mk(one42 << 2, -2, 29, 1'b1, 2'b10), 16'hFC00, 4'b0101);
    run_directed("tie_odd_rne", mk(one42 | (one42 >> 10) | (one42 >> 11), 0, 15, 1'b0, 2'b01), 16'h3C02, 4'b0001);
    run_directed("tie_even_rne", mk(one42 | (one42 >> 11), 0, 15, 1'b0, 2'b01), 16'h3C00, 4'b0001);
    run_directed("tie_odd_rz", mk(one42 | (one42 >> 10) | (one42 >> 11), 0, 15, 1'b0, 2'b00), 16'h3C01, 4'b0001);
    run_directed("g_rdn_neg", mk(one42 | (one42 >> 11), 0, 15, 1'b1, 2'b10), 16'hBC01, 4'b0001);
    run_directed("g_rup_pos", mk(one42 | (one42 >> 11), 0, 15, 1'b0, 2'b11), 16'h3C01, 4'b0001);
    run_directed("sub_rne", mk(one42 | 89'd1, 0, -5, 1'b0, 2'b01), 16'h0010, 4'b0011);
    run_directed("sub_rup", mk(one42 | 89'd1, 0, -5, 1'b0, 2'b11), 16'h0011, 4'b0011);
    run_directed("sub_to_norm", mk((one42 << 1) - 89'd1, 0, 0, 1'b0, 2'b01), 16'h0400, 4'b0011);
    cur = mk('0, 0, 0, 1'b1, 2'b01);
    cur.zero = 1'b1;
    run_directed("zero_neg", cur, 16'h8000, 4'b0000);

    $display("[TB] back-pressure burst");
    for (int i = 0; i < 5; i++) bp[i] = rand_beat();
    popped = 0;
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      bus.out_ready = !(c >= 4 && c <= 6);
      if (k < 5) apply_stimulus(bp[k], 1'b1);
      else apply_stimulus(bp[0], 1'b0);
      #1;
      if (c >= 4 && c <= 6) begin
        check_output("bp_in_ready", bus.in_ready, 0);
        check_output("bp_out_valid", bus.out_valid, 1);
        if (exp_q.size() > 0) check_output("bp_hold", {bus.flags, bus.result}, exp_q[0]);
      end
      tick();
      if (last_accept) k++;
    end
    check_output("bp_count", popped, 5);
    check_output("bp_queue_empty", exp_q.size(), 0);

    $display("[TB] reset with beats in flight");
    bus.out_ready = 1'b1;
    apply_stimulus(rand_beat(), 1'b1);
    tick();
    apply_stimulus(rand_beat(), 1'b1);
    tick();
    reset = 1'b0;
    exp_q.delete();
    apply_stimulus(cur_beat, 1'b0);
    #1;
    check_output("midrst_out_valid", bus.out_valid, 0);
    check_output("midrst_in_ready", bus.in_ready, 1);
    tick();
    tick();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_output("after_rst_no_out", bus.out_valid, 0);
    end
    run_directed("after_rst", mk(one42, 0, 15, 1'b0, 2'b01), 16'h3C00, 4'b0000);

    $display("[TB] randomized traffic");
    popped = 0;
    cur = rand_beat();
    for (int c = 0; c < 400; c++) begin
      bus.out_ready = ($urandom_range(3, 0) != 0);
      apply_stimulus(cur, ($urandom_range(3, 0) != 0));
      tick();
      if (last_accept) cur = rand_beat();
    end
    apply_stimulus(cur, 1'b0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick();
    check_output("drain_empty", exp_q.size(), 0);
    tick();
    check_output("idle_out_valid", bus.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fma16_norm_round.md
# fma16_norm_round

Sequential back end of the fma16 datapath: consumes the centred sum mantissa and the signed normalization shift produced by the leading-one finder, applies the shift, rounds to fp16 under the selected rounding mode, and packs the result with exception flags. Three-stage pipeline with valid/ready handshakes on both sides; sits between the sum/leading-one logic and the fma16 result register.

## Interface
- VEC_SIZE, 88: MSB index of sum mantissa `sm`
- END_BITS, 22: guard/sticky bits below the product LSB; unshifted leading-one weight 2^0 sits at bit END_BITS+20
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low (asserted when 0)
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- sm  in  VEC_SIZE+1  unsigned sum magnitude
- m_shift  in  8  signed left-shift amount (negative = right shift)
- pe  in  8  signed biased exponent of value at bit END_BITS+20
- sign  in  1  result sign
- zero_in  in  1  exact zero sum
- roundmode  in  2  00 RZ, 01 RNE, 10 RDN, 11 RUP
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  16  packed fp16
- flags  out  4  {invalid, overflow, underflow, inexact}; invalid always 0 here

## Operation
- Pipeline advance: adv = !out_valid | out_ready; in_ready = adv. All three stage registers load only on adv; a beat enters on in_valid & in_ready.
- S1 (shift): ns = (m_shift ≥ 0) ? sm << m_shift : sm >> -m_shift; bits shifted off the right OR into sticky. e = pe − m_shift (10-bit signed). If e ≤ 0: further right shift by 1−e (saturate at 24), sticky accumulates, e := 0, subnormal flag set.
- S2 (round): frac = ns[END_BITS+19:END_BITS+10], g = ns[END_BITS+9], st = sticky | |ns[END_BITS+8:0]. inc: RZ 0; RNE g&(st|frac[0]); RDN sign&(g|st); RUP !sign&(g|st). inexact = g|st. Fraction carry-out increments e (normal) or sets e=1 (subnormal becoming normal).
- S3 (pack/flags): e ≥ 31 → overflow, inexact; result = ±Inf for RNE, RUP(+), RDN(−); else ±0x7BFF magnitude. Subnormal and inexact → underflow. zero_in → result {sign,15'b0}, flags 0, except sign forced 0 unless roundmode=RDN when sign differs is signalled via sign input (sign used as given).
- All arithmetic on exponent is 10-bit signed; no truncation before overflow compare.

## Timing
- Latency 3 cycles from accepted beat to out_valid, given out_ready held high; throughput 1/cycle.
- Reset: out_valid=0, result=0, flags=0, all stage valids 0; in_ready=1 during and after reset.
- Stall: out_valid & !out_ready freezes every stage; result/flags stable until accepted; in_ready=0.
- Simultaneous accept at output and input: both occur same cycle, no bubble.
- Reset asserted mid-operation: all in-flight beats discarded; no partial output after release.
- in_valid may drop between beats; bubbles propagate as stage valid=0.

## Structure
- Shared package fma16_pkg: rounding-mode enum (RZ, RNE, RDN, RUP), flag bit indices, fp16 constants (BIAS=15, EMAX=31, MAXNORM=15'h7BFF, INF=15'h7C00).
- One sub-module: fma16_round_inc (combinational increment decision from roundmode, sign, lsb, g, st).

## Test plan
- sm bit END_BITS+20 set only, m_shift=0, pe=15, sign=0, RNE → result 0x3C00, flags 0000, out_valid 3 cycles after accept.
- sm bits END_BITS+22 set, m_shift=−2, pe=15, RNE → 0x4400 (4.0); same with pe=29, m_shift=−2 → e=31, 0x7C00, flags 0101; RZ → 0x7BFF, flags 0101.
- Tie: frac lsb=1, g=1, st=0, RNE → frac+1, inexact; lsb=0 → unchanged, inexact; RZ → unchanged.
- pe=−5, m_shift=0 → subnormal right shift 6, e field 0, underflow=1 when inexact.
- Back-pressure: 5 back-to-back beats, out_ready low cycles 4–6 → in_ready low while stalled, results emerged in order, none lost/duplicated.
- reset low during cycle 2 with 2 beats in flight → out_valid stays 0, next beat after release completes normally.
